// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-ported memory between
// fetch and data ports; data wins, bounded by a fetch starvation limit.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [DATA_W-1:0] if_data_d, dm_rdata_d;
  logic              if_ready_d, dm_ready_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              busy_d, err_d;
  logic              grant_d;
  logic              tmo;

  assign grant_d = dm_req_i && (!if_req_i || (streak_q < SLIM));
  assign tmo     = TO_EN && (tcnt_q == TLAST);

  // Next-state, counters and next registered output values.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    if_data_d   = if_data_o;
    dm_rdata_d  = dm_rdata_o;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          tcnt_d      = '0;
          if (!if_req_i)
            streak_d = '0;
          else if (streak_q != SLIM)
            streak_d = streak_q + SW'(1);
        end else if (if_req_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          tcnt_d      = '0;
          streak_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        tcnt_d = tcnt_q + TW'(1);
        if (mem_ack_i || tmo) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          err_d     = !mem_ack_i;
          if (state_q == BUSY_I) begin
            if_ready_d = 1'b1;
            if (mem_ack_i)
              if_data_d = mem_rdata_i;
          end else begin
            dm_ready_d = 1'b1;
            if (mem_ack_i && !mem_we_o)
              dm_rdata_d = mem_rdata_i;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tcnt_q      <= '0;
      if_data_o   <= '0;
      if_ready_o  <= 1'b0;
      dm_rdata_o  <= '0;
      dm_ready_o  <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
      if_data_o   <= if_data_d;
      if_ready_o  <= if_ready_d;
      dm_rdata_o  <= dm_rdata_d;
      dm_ready_o  <= dm_ready_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      busy_o      <= busy_d;
      err_o       <= err_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: fetch, data priority,
// starvation limit, writes, timeout abort and mid-access reset.
module tb_unified_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        err_o;

  int errs = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  unified_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4),
    .TIMEOUT(8)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .if_req_i(if_req_i),
    .if_addr_i(if_addr_i),
    .if_data_o(if_data_o),
    .if_ready_o(if_ready_o),
    .dm_req_i(dm_req_i),
    .dm_we_i(dm_we_i),
    .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o),
    .dm_ready_o(dm_ready_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] order [6];

  initial begin
    order[0] = 32'h200; order[1] = 32'h200;
    order[2] = 32'h200; order[3] = 32'h200;
    order[4] = 32'h100; order[5] = 32'h200;

    rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0;
    dm_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_if_ready", {31'b0, if_ready_o}, 32'd0);
    chk("rst_dm_ready", {31'b0, dm_ready_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_if_data", if_data_o, 32'd0);
    chk("rst_dm_rdata", dm_rdata_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // Single fetch, zero-latency ack.
    if_req_i = 1'b1; if_addr_i = 32'h10;
    tick();
    chk("f1_mem_req", {31'b0, mem_req_o}, 32'd1);
    chk("f1_mem_addr", mem_addr_o, 32'h10);
    chk("f1_mem_we", {31'b0, mem_we_o}, 32'd0);
    chk("f1_busy", {31'b0, busy_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    chk("f1_if_ready", {31'b0, if_ready_o}, 32'd1);
    chk("f1_if_data", if_data_o, 32'hDEADBEEF);
    chk("f1_req_drop", {31'b0, mem_req_o}, 32'd0);
    chk("f1_no_dm_ready", {31'b0, dm_ready_o}, 32'd0);
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    tick();
    chk("f1_busy_low", {31'b0, busy_o}, 32'd0);
    chk("f1_ready_low", {31'b0, if_ready_o}, 32'd0);

    // Simultaneous requests, ack latency 2: data first.
    if_req_i = 1'b1; if_addr_i = 32'h20;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    tick();
    chk("pr_first_addr", mem_addr_o, 32'h40);
    tick();
    chk("pr_wait_req", {31'b0, mem_req_o}, 32'd1);
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE0040;
    tick();
    chk("pr_dm_ready", {31'b0, dm_ready_o}, 32'd1);
    chk("pr_dm_rdata", dm_rdata_o, 32'hCAFE0040);
    chk("pr_no_if_ready", {31'b0, if_ready_o}, 32'd0);
    dm_req_i = 1'b0; mem_ack_i = 1'b0;
    tick();
    tick();
    chk("pr_fetch_addr", mem_addr_o, 32'h20);
    chk("pr_fetch_req", {31'b0, mem_req_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11112222;
    tick();
    chk("pr_if_ready", {31'b0, if_ready_o}, 32'd1);
    chk("pr_if_data", if_data_o, 32'h11112222);
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    tick();

    // Starvation limit: D,D,D,D,I,D with both requests held.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk($sformatf("starve_grant%0d", g), mem_addr_o, order[g]);
      tick();
      tick();
    end
    if_req_i = 1'b0; dm_req_i = 1'b0; mem_ack_i = 1'b0;
    tick();

    // Data write: bus latched and stable, read data untouched.
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h80;
    dm_wdata_i = 32'h12345678;
    tick();
    chk("wr_we", {31'b0, mem_we_o}, 32'd1);
    chk("wr_addr", mem_addr_o, 32'h80);
    chk("wr_wdata", mem_wdata_o, 32'h12345678);
    dm_wdata_i = 32'hFFFFFFFF;
    tick();
    chk("wr_wdata_hold", mem_wdata_o, 32'h12345678);
    chk("wr_req_hold", {31'b0, mem_req_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
    tick();
    chk("wr_dm_ready", {31'b0, dm_ready_o}, 32'd1);
    chk("wr_rdata_keep", dm_rdata_o, 32'h55AA55AA);
    chk("wr_no_err", {31'b0, err_o}, 32'd0);
    dm_req_i = 1'b0; dm_we_i = 1'b0; mem_ack_i = 1'b0;
    tick();

    // Timeout: 8 busy cycles without ack, then abort.
    dm_req_i = 1'b1; dm_addr_i = 32'hC0;
    tick();
    chk("to_req_start", {31'b0, mem_req_o}, 32'd1);
    repeat (7) tick();
    chk("to_req_8th", {31'b0, mem_req_o}, 32'd1);
    chk("to_no_ready_8th", {31'b0, dm_ready_o}, 32'd0);
    tick();
    chk("to_req_drop", {31'b0, mem_req_o}, 32'd0);
    chk("to_dm_ready", {31'b0, dm_ready_o}, 32'd1);
    chk("to_err", {31'b0, err_o}, 32'd1);
    chk("to_rdata_keep", dm_rdata_o, 32'h55AA55AA);
    dm_req_i = 1'b0;
    tick();
    chk("to_err_low", {31'b0, err_o}, 32'd0);
    chk("to_idle", {31'b0, busy_o}, 32'd0);

    // Reset during a fetch; the late ack must be ignored.
    if_req_i = 1'b1; if_addr_i = 32'h300;
    tick();
    chk("rb_busy_i", {31'b0, mem_req_o}, 32'd1);
    rst_i = 1'b1; if_req_i = 1'b0;
    tick();
    chk("rb_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rb_mem_addr", mem_addr_o, 32'd0);
    chk("rb_dm_rdata", dm_rdata_o, 32'd0);
    chk("rb_busy", {31'b0, busy_o}, 32'd0);
    rst_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    tick();
    chk("rb_no_ready", {31'b0, if_ready_o}, 32'd0);
    chk("rb_if_data", if_data_o, 32'd0);
    chk("rb_still_idle", {31'b0, busy_o}, 32'd0);
    mem_ack_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h304;
    tick();
    chk("rb_next_addr", mem_addr_o, 32'h304);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h600D600D;
    tick();
    chk("rb_next_ready", {31'b0, if_ready_o}, 32'd1);
    chk("rb_next_data", if_data_o, 32'h600D600D);
    if_req_i = 1'b0; mem_ack_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch port and the data-memory port of the 5-stage pipeline. Requests are level/handshake based and memory latency is variable (ack driven). Data port has priority, but a starvation limit guarantees forward progress for fetch. A timeout guard aborts hung accesses. Requesters stall on their own ready; the block is their only path to memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, max consecutive data grants while fetch waits (>=1)
TIMEOUT, 255, cycles in BUSY without ack before abort; 0 disables

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
if_req_i  in  1  fetch request, held until if_ready_o
if_addr_i  in  ADDR_W  fetch address
if_data_o  out  DATA_W  fetched word, valid when if_ready_o
if_ready_o  out  1  one-cycle completion pulse, fetch port
dm_req_i  in  1  data request, held until dm_ready_o
dm_we_i  in  1  1=write, 0=read
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  write data
dm_rdata_o  out  DATA_W  read data, valid when dm_ready_o on a read
dm_ready_o  out  1  one-cycle completion pulse, data port
mem_req_o  out  1  request to memory, held until ack
mem_we_o  out  1  write enable to memory
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completion (may be same cycle as mem_req_o)
mem_rdata_i  in  DATA_W  memory read data, valid with ack
busy_o  out  1  high in BUSY or RESP
err_o  out  1  one-cycle pulse with ready on timeout abort

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP. All outputs registered.
- Reset (sync, rst_i high at edge): state IDLE; every output 0 (incl. data outputs, mem_* bus); streak and timeout counters 0. Reset mid-transaction abandons the access; mem_req_o low next cycle; a late ack is ignored.
- IDLE arbitration (one decision per cycle):
  - dm_req_i && (!if_req_i || streak < STARVE_LIMIT) -> BUSY_D.
  - else if_req_i -> BUSY_I.
  - neither -> stay IDLE.
  - On grant: latch addr/we/wdata into mem_* (fetch: mem_we_o=0, mem_wdata_o=0); mem_req_o=1 from next cycle.
- Streak counter: on D grant, increment (saturating at STARVE_LIMIT) if if_req_i high, else clear; cleared on I grant.
- BUSY_x: mem_* held stable; timeout counter increments each cycle.
  - mem_ack_i high -> RESP; mem_req_o=0 next cycle. Fetch or data read: capture mem_rdata_i into if_data_o/dm_rdata_o. Data write: dm_rdata_o unchanged.
  - counter reaches TIMEOUT (TIMEOUT>0) without ack -> RESP with err_o=1; data output unchanged; mem_req_o dropped.
- RESP (exactly one cycle): the granted port's ready pulses 1; err_o pulses if aborted; no arbitration; next state IDLE. The requester may hold req high with a new address in this cycle; that is treated as a new request in the following IDLE.
- Latency: req seen in IDLE at cycle 0 -> mem_req_o cycle 1 -> ack at cycle 1+k (k>=0) -> ready at cycle 2+k. Minimum 3 cycles per transaction.
- Request withdrawn during BUSY: access completes and ready still pulses.
- mem_ack_i in IDLE/RESP ignored.
- Only one ready asserted per cycle; never both.
- busy_o = state in {BUSY_I, BUSY_D, RESP}.

Test Plan:
- Reset then single fetch addr 0x10, mem acks same cycle as mem_req_o with 0xDEADBEEF -> mem_req_o on cycle 1, if_ready_o=1 with if_data_o=0xDEADBEEF on cycle 2, busy_o low cycle 3.
- Simultaneous if_req_i and dm_req_i (read 0x40), ack latency 2 -> data served first (dm_ready_o cycle 4); fetch granted in next IDLE.
- Continuous dm_req_i plus if_req_i, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D...; no 5th consecutive D grant.
- Data write 0x80/0x12345678 -> mem_we_o=1, mem_wdata_o=0x12345678 stable until ack; dm_ready_o pulses; dm_rdata_o keeps prior value.
- TIMEOUT=8, never ack -> after 8 BUSY cycles mem_req_o drops; next cycle dm_ready_o=1 and err_o=1; arbiter back to IDLE.
- rst_i asserted in BUSY_I, ack arrives the cycle after -> all outputs 0, no if_ready_o, ack ignored, next fetch served normally.
